// File: rtl/evt_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | evt_pkg                                                           |
// | Shared constants for the event arbiter slice.                     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package evt_pkg;

    localparam int N_EVT   = 4;
    localparam int IDW_EVT = (N_EVT > 1) ? $clog2(N_EVT) : 1;

    localparam logic EVT_FALL = 1'b0;
    localparam logic EVT_RISE = 1'b1;

    function automatic int evt_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/evt_sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | evt_sync_edge                                                     |
// | One channel: 3-flop synchronizer with edge pulse and level.       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module evt_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic e,
    output logic lv
);

    (* ASYNC_REG = "TRUE" *) logic r_s1;
    (* ASYNC_REG = "TRUE" *) logic r_s2;
    logic r_s3;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign e  = r_s2 ^ r_s3;
    assign lv = r_s2;

endmodule
`default_nettype wire

// File: rtl/event_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | event_arbiter                                                     |
// | Latches edges from N async inputs, delivers them round-robin.     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module event_arbiter
    import evt_pkg::*;
#(
    parameter int N   = N_EVT,
    parameter int IDW = evt_idw(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   async_in,
    output logic           evt_valid,
    input  logic           evt_ready,
    output logic [IDW-1:0] evt_id,
    output logic           evt_level,
    output logic [N-1:0]   pend,
    output logic [N-1:0]   ovf,
    input  logic [N-1:0]   ovf_clr
);

    logic [N-1:0]   w_e;
    logic [N-1:0]   w_lv;
    logic [N-1:0]   r_pend;
    logic [N-1:0]   r_lvl;
    logic [N-1:0]   r_ovf;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_win;
    logic [IDW-1:0] w_cand;
    logic           w_any;
    logic           w_free;
    logic           w_load;
    logic [N-1:0]   w_grant;

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        evt_sync_edge u_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (async_in[gi]),
            .e        (w_e[gi]),
            .lv       (w_lv[gi])
        );
    end

    // Scan from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        w_win  = r_ptr;
        w_any  = 1'b0;
        w_cand = '0;
        for (int k = N; k >= 1; k--) begin
            w_cand = IDW'((int'(r_ptr) + k) % N);
            if (r_pend[w_cand]) begin
                w_win = w_cand;
                w_any = 1'b1;
            end
        end
    end

    assign w_free  = !evt_valid || evt_ready;
    assign w_load  = w_free && w_any;
    assign w_grant = w_load ? (N'(1) << w_win) : '0;

    // A fresh edge on the channel being loaded re-arms pend without overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend    <= '0;
            r_lvl     <= '0;
            r_ovf     <= '0;
            r_ptr     <= IDW'(N - 1);
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_level <= 1'b0;
        end else begin
            r_pend <= w_e | (r_pend & ~w_grant);
            r_lvl  <= (r_lvl & ~w_e) | (w_lv & w_e);
            r_ovf  <= (w_e & r_pend & ~w_grant) | (r_ovf & ~ovf_clr);
            if (w_load) begin
                evt_valid <= 1'b1;
                evt_id    <= w_win;
                evt_level <= r_lvl[w_win];
                r_ptr     <= w_win;
            end else if (w_free) begin
                evt_valid <= 1'b0;
            end
        end
    end

    assign pend = r_pend;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_event_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_event_arbiter                                                  |
// | Directed scenarios plus randomized run against a reference model. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_event_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   async_in = '0;
    logic [N-1:0]   ovf_clr = '0;
    logic           evt_ready = 1'b0;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic           evt_level;
    logic [N-1:0]   pend;
    logic [N-1:0]   ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: sampling history, pending table, output slot.
    logic [N-1:0] h1 = '0, h2 = '0, h3 = '0;
    logic [N-1:0] m_pend = '0, m_lvl = '0, m_ovf = '0;
    logic         m_valid = 1'b0, m_level = 1'b0;
    int           m_id = 0, m_ptr = N - 1;

    event_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_level (evt_level),
        .pend      (pend),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        logic [N-1:0] ev, np, nl, no;
        logic free, load, g;
        int win;
        if (!rst) begin
            h1 = '0; h2 = '0; h3 = '0;
            m_pend = '0; m_lvl = '0; m_ovf = '0;
            m_valid = 1'b0; m_level = 1'b0; m_id = 0; m_ptr = N - 1;
            return;
        end
        ev   = h2 ^ h3;
        free = !m_valid || evt_ready;
        win  = -1;
        for (int k = 1; k <= N; k++)
            if (win < 0 && m_pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        load = free && (win >= 0);
        for (int i = 0; i < N; i++) begin
            g     = load && (i == win);
            np[i] = ev[i] | (m_pend[i] & ~g);
            nl[i] = ev[i] ? h2[i] : m_lvl[i];
            no[i] = (ev[i] & m_pend[i] & ~g) | (m_ovf[i] & ~ovf_clr[i]);
        end
        if (load) begin
            m_valid = 1'b1; m_id = win; m_level = m_lvl[win]; m_ptr = win;
        end else if (free) begin
            m_valid = 1'b0;
        end
        m_pend = np; m_lvl = nl; m_ovf = no;
        h3 = h2; h2 = h1; h1 = async_in;
    endtask

    task automatic tick(input int n = 1);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; async_in = '0; evt_ready = 1'b0; ovf_clr = '0;
        tick(3);
        n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", evt_valid); end
        n_tests++; if (evt_id !== 2'd0) begin n_fail++; $display("FAIL rst_id: got %0d exp 0", evt_id); end
        n_tests++; if (evt_level !== 1'b0) begin n_fail++; $display("FAIL rst_level: got %b exp 0", evt_level); end
        n_tests++; if (pend !== 4'b0000) begin n_fail++; $display("FAIL rst_pend: got %b exp 0000", pend); end
        n_tests++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL rst_ovf: got %b exp 0000", ovf); end
    endtask

    task automatic test_round_robin();
        logic [IDW-1:0] exp_id [3];
        logic           exp_lv [3];
        rst = 1'b1; evt_ready = 1'b1; async_in = 4'b1011;
        tick(3);
        n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rr_early: got %b exp 0", evt_valid); end
        exp_id = '{2'd0, 2'd1, 2'd3};
        for (int j = 0; j < 3; j++) begin
            tick();
            n_tests++; if (evt_valid !== 1'b1 || evt_id !== exp_id[j] || evt_level !== 1'b1) begin
                n_fail++; $display("FAIL rr_rise[%0d]: got v=%b id=%0d lv=%b exp v=1 id=%0d lv=1", j, evt_valid, evt_id, evt_level, exp_id[j]);
            end
        end
        tick();
        n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got %b exp 0", evt_valid); end
        async_in = 4'b1001;
        tick(4);
        n_tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_level !== 1'b0) begin
            n_fail++; $display("FAIL rr_g1: got v=%b id=%0d lv=%b exp v=1 id=1 lv=0", evt_valid, evt_id, evt_level);
        end
        tick();
        async_in = 4'b0010;
        tick(3);
        exp_id = '{2'd3, 2'd0, 2'd1};
        exp_lv = '{1'b0, 1'b0, 1'b1};
        for (int j = 0; j < 3; j++) begin
            tick();
            n_tests++; if (evt_valid !== 1'b1 || evt_id !== exp_id[j] || evt_level !== exp_lv[j]) begin
                n_fail++; $display("FAIL rr_mix[%0d]: got v=%b id=%0d lv=%b exp v=1 id=%0d lv=%b", j, evt_valid, evt_id, evt_level, exp_id[j], exp_lv[j]);
            end
        end
        tick();
    endtask

    task automatic test_latency();
        evt_ready = 1'b0; async_in = 4'b0110;
        tick(2);
        n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL lat_e1: got %b exp 0", evt_valid); end
        tick();
        n_tests++; if (evt_valid !== 1'b0 || pend !== 4'b0100) begin
            n_fail++; $display("FAIL lat_e2: got v=%b pend=%b exp v=0 pend=0100", evt_valid, pend);
        end
        tick();
        n_tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_level !== 1'b1 || pend !== 4'b0000) begin
            n_fail++; $display("FAIL lat_e3: got v=%b id=%0d lv=%b pend=%b exp v=1 id=2 lv=1 pend=0000", evt_valid, evt_id, evt_level, pend);
        end
        evt_ready = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        async_in = 4'b0000; evt_ready = 1'b1;
        tick(8);
        evt_ready = 1'b0; async_in = 4'b0010;
        tick(4);
        async_in = 4'b0011;
        for (int j = 0; j < 10; j++) begin
            n_tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd1 || evt_level !== 1'b1) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d lv=%b exp v=1 id=1 lv=1", j, evt_valid, evt_id, evt_level);
            end
            tick();
        end
        n_tests++; if (pend !== 4'b0001) begin n_fail++; $display("FAIL bp_pend: got %b exp 0001", pend); end
        evt_ready = 1'b1;
        tick();
        n_tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_level !== 1'b1) begin
            n_fail++; $display("FAIL bp_next: got v=%b id=%0d lv=%b exp v=1 id=0 lv=1", evt_valid, evt_id, evt_level);
        end
        tick();
    endtask

    task automatic test_overflow();
        async_in = 4'b0000; evt_ready = 1'b1;
        tick(8);
        evt_ready = 1'b0; async_in = 4'b0010;
        tick(4);
        async_in = 4'b0110;
        tick(4);
        async_in = 4'b0010;
        tick(4);
        n_tests++; if (pend[2] !== 1'b1 || ovf[2] !== 1'b1 || evt_id !== 2'd1) begin
            n_fail++; $display("FAIL ovf_set: got pend2=%b ovf2=%b id=%0d exp 1 1 1", pend[2], ovf[2], evt_id);
        end
        evt_ready = 1'b1;
        tick();
        n_tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd2 || evt_level !== 1'b0) begin
            n_fail++; $display("FAIL ovf_lvl: got v=%b id=%0d lv=%b exp v=1 id=2 lv=0", evt_valid, evt_id, evt_level);
        end
        ovf_clr = 4'b0100;
        tick();
        ovf_clr = 4'b0000;
        n_tests++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL ovf_clr: got %b exp 0000", ovf); end
        evt_ready = 1'b0; async_in = 4'b0000;
        tick(4);
        async_in = 4'b0100;
        tick(4);
        async_in = 4'b0000;
        tick(2);
        ovf_clr = 4'b0100;
        tick();
        ovf_clr = 4'b0000;
        n_tests++; if (ovf[2] !== 1'b1 || pend[2] !== 1'b1) begin
            n_fail++; $display("FAIL ovf_setclr: got ovf2=%b pend2=%b exp 1 1", ovf[2], pend[2]);
        end
        evt_ready = 1'b1;
        tick(8);
        ovf_clr = 4'b1111;
        tick();
        ovf_clr = 4'b0000;
    endtask

    task automatic test_coincident();
        evt_ready = 1'b0; async_in = 4'b0010;
        tick(4);
        async_in = 4'b0011;
        tick(3);
        n_tests++; if (pend !== 4'b0001) begin n_fail++; $display("FAIL co_pend0: got %b exp 0001", pend); end
        async_in = 4'b0010;
        tick(2);
        evt_ready = 1'b1;
        tick();
        n_tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_level !== 1'b1 || pend[0] !== 1'b1 || ovf[0] !== 1'b0) begin
            n_fail++; $display("FAIL co_load: got v=%b id=%0d lv=%b pend0=%b ovf0=%b exp 1 0 1 1 0", evt_valid, evt_id, evt_level, pend[0], ovf[0]);
        end
        tick();
        n_tests++; if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_level !== 1'b0) begin
            n_fail++; $display("FAIL co_second: got v=%b id=%0d lv=%b exp v=1 id=0 lv=0", evt_valid, evt_id, evt_level);
        end
        tick();
        n_tests++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL co_idle: got %b exp 0", evt_valid); end
    endtask

    task automatic test_reset_mid();
        async_in = 4'b0000; evt_ready = 1'b1;
        tick(8);
        evt_ready = 1'b0; async_in = 4'b0100;
        tick(4);
        async_in = 4'b1111;
        tick(3);
        n_tests++; if (pend !== 4'b1011 || evt_valid !== 1'b1) begin
            n_fail++; $display("FAIL rm_pre: got pend=%b v=%b exp 1011 1", pend, evt_valid);
        end
        async_in = 4'b0000; rst = 1'b0;
        tick();
        rst = 1'b1;
        n_tests++; if (evt_valid !== 1'b0 || evt_id !== 2'd0 || evt_level !== 1'b0 || pend !== 4'b0000 || ovf !== 4'b0000) begin
            n_fail++; $display("FAIL rm_clear: got v=%b id=%0d lv=%b pend=%b ovf=%b exp all 0", evt_valid, evt_id, evt_level, pend, ovf);
        end
        for (int j = 0; j < 10; j++) begin
            tick();
            n_tests++; if (evt_valid !== 1'b0 || pend !== 4'b0000) begin
                n_fail++; $display("FAIL rm_quiet[%0d]: got v=%b pend=%b exp 0 0000", j, evt_valid, pend);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) async_in[i] = ~async_in[i];
            evt_ready = ($urandom_range(0, 9) < 6);
            ovf_clr   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            rst       = ($urandom_range(0, 299) != 0);
            tick();
            n_tests++; if (evt_valid !== m_valid) begin
                n_fail++; $display("FAIL rnd_valid@%0d: got %b exp %b", c, evt_valid, m_valid);
            end
            if (m_valid) begin
                n_tests++; if (evt_id !== IDW'(m_id) || evt_level !== m_level) begin
                    n_fail++; $display("FAIL rnd_evt@%0d: got id=%0d lv=%b exp id=%0d lv=%b", c, evt_id, evt_level, m_id, m_level);
                end
            end
            n_tests++; if (pend !== m_pend) begin
                n_fail++; $display("FAIL rnd_pend@%0d: got %b exp %b", c, pend, m_pend);
            end
            n_tests++; if (ovf !== m_ovf) begin
                n_fail++; $display("FAIL rnd_ovf@%0d: got %b exp %b", c, ovf, m_ovf);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_latency();
        test_backpressure();
        test_overflow();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
